taxi_eth_rx_mac_filter: RTL

Destination-MAC address filter on the 8-bit receive AXI stream. It sits directly downstream of the 1G GMII MAC+FIFO receive port (m_axis_rx) in the logic_clk domain, ahead of the host/packet-processing logic. The block buffers the 6-byte destination address and then either forwards or discards the whole frame, based on unicast/broadcast/multicast/promiscuous configuration. It also counts the frames it drops.

---
 rtl/taxi_eth_rx_mac_filter_if.sv | 21 ++
 rtl/taxi_eth_rx_mac_filter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/taxi_eth_rx_mac_filter_if.sv
// AXI-stream bundle for the RX MAC filter; byte-wide data with one user bit.
interface taxi_eth_rx_mac_filter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned USER_W = 1,
  parameter int unsigned ID_W   = 8,
  parameter int unsigned DEST_W = 8
) ();
  localparam int unsigned KEEP_W = (DATA_W + 7) / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/taxi_eth_rx_mac_filter.sv
// Destination-MAC filter: buffers the 6-byte DA, then replays and passes the
// frame through or discards it; counts dropped and runt frames.
module taxi_eth_rx_mac_filter #(
  parameter int unsigned DROP_CNT_W = 32,
  parameter int unsigned HDR_LEN    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  taxi_eth_rx_mac_filter_if.slave  s_axis,
  taxi_eth_rx_mac_filter_if.master m_axis,
  input  logic [47:0]           cfg_mac_addr,
  input  logic                  cfg_promisc,
  input  logic                  cfg_bcast_en,
  input  logic                  cfg_mcast_en,
  output logic                  stat_frame_accept,
  output logic                  stat_frame_drop,
  output logic                  stat_frame_runt,
  output logic [DROP_CNT_W-1:0] drop_count
);
  localparam int unsigned IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_LEN - 1);

  typedef enum logic [1:0] {ST_HDR, ST_REPLAY, ST_PASS, ST_DROP} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [HDR_LEN-1:0][7:0]   hdr_q, hdr_d;
  logic                      accept_q, accept_d;
  logic                      drop_q, drop_d;
  logic                      runt_q, runt_d;
  logic [DROP_CNT_W-1:0]     cnt_q, cnt_d;
  logic                      cnt_inc;

  logic [47:0] da;
  logic        bcast;
  logic        match;
  logic        s_tready;
  logic        m_tvalid;
  logic [7:0]  m_tdata;
  logic        m_tlast;
  logic        m_tuser;
  logic        unused_sideband;

  // Decision uses the live 6th byte so the frame can be judged on its final header beat
  assign da    = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], s_axis.tdata};
  assign bcast = &da;
  assign match = cfg_promisc | (da == cfg_mac_addr) | (cfg_bcast_en & bcast) |
                 (cfg_mcast_en & da[40] & ~bcast);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hdr_d    = hdr_q;
    accept_d = 1'b0;
    drop_d   = 1'b0;
    runt_d   = 1'b0;
    cnt_inc  = 1'b0;
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = 8'h00;
    m_tlast  = 1'b0;
    m_tuser  = 1'b0;
    case (state_q)
      ST_HDR: begin
        s_tready = 1'b1;
        if (s_axis.tvalid) begin
          hdr_d[idx_q] = s_axis.tdata;
          if (s_axis.tlast) begin
            runt_d  = 1'b1;
            cnt_inc = 1'b1;
            idx_d   = '0;
          end else if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = match ? ST_REPLAY : ST_DROP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_REPLAY: begin
        m_tvalid = 1'b1;
        m_tdata  = hdr_q[idx_q];
        if (m_axis.tready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_PASS;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PASS: begin
        m_tvalid = s_axis.tvalid;
        s_tready = m_axis.tready;
        m_tdata  = s_axis.tdata;
        m_tlast  = s_axis.tlast;
        m_tuser  = s_axis.tuser[0];
        if (s_axis.tvalid && m_axis.tready && s_axis.tlast) begin
          accept_d = 1'b1;
          state_d  = ST_HDR;
        end
      end
      ST_DROP: begin
        s_tready = 1'b1;
        if (s_axis.tvalid && s_axis.tlast) begin
          drop_d  = 1'b1;
          cnt_inc = 1'b1;
          state_d = ST_HDR;
        end
      end
      default: state_d = ST_HDR;
    endcase
    cnt_d = (cnt_inc && (cnt_q != '1)) ? cnt_q + DROP_CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HDR;
      idx_q    <= '0;
      hdr_q    <= '0;
      accept_q <= 1'b0;
      drop_q   <= 1'b0;
      runt_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hdr_q    <= hdr_d;
      accept_q <= accept_d;
      drop_q   <= drop_d;
      runt_q   <= runt_d;
      cnt_q    <= cnt_d;
    end
  end

  // Input is never accepted while reset is held
  assign s_axis.tready = s_tready & ~rst;
  assign m_axis.tvalid = m_tvalid;
  assign m_axis.tdata  = m_tdata;
  assign m_axis.tlast  = m_tlast;
  assign m_axis.tuser  = m_tuser;
  assign m_axis.tkeep  = 1'b1;
  assign m_axis.tid    = '0;
  assign m_axis.tdest  = '0;

  assign stat_frame_accept = accept_q;
  assign stat_frame_drop   = drop_q;
  assign stat_frame_runt   = runt_q;
  assign drop_count        = cnt_q;

  assign unused_sideband = ^{s_axis.tkeep, s_axis.tid, s_axis.tdest};
endmodule
